prisoner_seeker: RTL and testbench

PRISONER_SEEKER -- requirements
Module: prisoner_seeker

---
 rtl/prisoner_pkg.sv | 23 ++
 rtl/prisoner_seeker.sv | 110 +++++++++++
 tb/tb_prisoner_seeker.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/prisoner_pkg.sv
// Shared definitions for the prisoner/box subsystem. The seeker, the box
// array and the loader all import this package.
//   DEF_N_BOXES / DEF_MAX_OPENS : default box count and opening budget
//   GUARD_KEY                   : guard key constant used by the loader
//   box_idx_t                   : 8-bit box / prisoner index
//   seeker_state_t              : seeker FSM state encoding
package prisoner_pkg;

  localparam int unsigned DEF_N_BOXES   = 100;
  localparam int unsigned DEF_MAX_OPENS = 50;

  localparam logic [31:0] GUARD_KEY = 32'hDEADBEEF;

  typedef logic [7:0] box_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } seeker_state_t;

endpackage

// File: rtl/prisoner_seeker.sv
// Prisoner seeker: follows the box chain starting at box[prisoner_id] until
// the prisoner's own number is found, the opening budget runs out, or an
// illegal box content is seen. Every opening is a read strobe cycle (ISSUE)
// followed by a compare cycle (CAPTURE) on the registered box content.
//   clk, rst     : clock, synchronous active-low reset
//   start        : search request, sampled only in IDLE
//   prisoner_id  : number sought, captured on an accepted start
//   box_sel      : index of the box being opened (drives external read mux)
//   box_rd_en    : one-cycle read strobe to the box array
//   box_data     : registered box content, valid in the cycle after box_rd_en
//   busy         : accepted start through the done cycle, inclusive
//   done         : single-cycle completion pulse
//   found        : search succeeded, held until the next accepted start
//   error        : illegal id or box content, held until the next accepted start
//   opens_used   : boxes opened in the last search, held likewise
module prisoner_seeker
  import prisoner_pkg::*;
#(
  parameter int unsigned N_BOXES   = DEF_N_BOXES,
  parameter int unsigned MAX_OPENS = DEF_MAX_OPENS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] prisoner_id,
  output logic [7:0] box_sel,
  output logic       box_rd_en,
  input  logic [7:0] box_data,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       error,
  output logic [7:0] opens_used
);

  localparam box_idx_t N_LIM   = box_idx_t'(N_BOXES);
  localparam box_idx_t MAX_LIM = box_idx_t'(MAX_OPENS);

  seeker_state_t state;
  box_idx_t      target;

  // All outputs are registered; box_rd_en is raised on the edge that enters
  // ISSUE so it is high exactly for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      target     <= '0;
      box_sel    <= '0;
      box_rd_en  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      error      <= 1'b0;
      opens_used <= '0;
    end else begin
      box_rd_en <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            found      <= 1'b0;
            error      <= 1'b0;
            opens_used <= '0;
            if (prisoner_id < N_LIM) begin
              target    <= prisoner_id;
              box_sel   <= prisoner_id;
              box_rd_en <= 1'b1;
              state     <= ISSUE;
            end else begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          opens_used <= opens_used + 8'd1;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          // Rule order matters: bad content wins over a match, and a match
          // on the last allowed opening still counts as found.
          if (box_data >= N_LIM) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (box_data == target) begin
            found <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (opens_used == MAX_LIM) begin
            found <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            box_sel   <= box_data;
            box_rd_en <= 1'b1;
            state     <= ISSUE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prisoner_seeker.sv
// Directed bench for prisoner_seeker with a registered box-array model.
module tb_prisoner_seeker;
  import prisoner_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] prisoner_id = '0;
  logic [7:0] box_sel;
  logic       box_rd_en;
  logic [7:0] box_data = '0;
  logic       busy, done, found, error;
  logic [7:0] opens_used;

  logic [7:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int sel_log [0:127];
  int nsel;
  int lat;
  int dcount;

  prisoner_seeker #(.N_BOXES(100), .MAX_OPENS(50)) dut (
    .clk(clk), .rst(rst), .start(start), .prisoner_id(prisoner_id),
    .box_sel(box_sel), .box_rd_en(box_rd_en), .box_data(box_data),
    .busy(busy), .done(done), .found(found), .error(error),
    .opens_used(opens_used)
  );

  always #5 clk = ~clk;

  // Box array: registered read, content valid the cycle after the strobe.
  always @(posedge clk) if (box_rd_en) box_data <= mem[box_sel];

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  endtask

  // Releases reset (if held) and presents start for exactly one sampling edge.
  // Returns at the negedge following the start-sampling edge.
  task automatic launch(input logic [7:0] id);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; prisoner_id = id;
    @(negedge clk);
    start = 1'b0;
  endtask

  // c counts rising edges after the start-sampling edge. Optionally re-pulses
  // start (with id 7) at cycle inj to check it is ignored. Returns at the
  // negedge where done is seen, or lat = -1 on timeout.
  task automatic wait_done(input int limit, input int inj, output int l);
    l = -1;
    nsel = 0;
    for (int c = 0; c < limit; c++) begin
      if (box_rd_en && nsel < 128) begin sel_log[nsel] = box_sel; nsel++; end
      if (done) begin l = c; break; end
      if (c == inj) begin start = 1'b1; prisoner_id = 8'd7; end
      if (c == inj + 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic after_done(input string tag);
    chk({tag, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_clr"}, busy, 0);
  endtask

  initial begin
    set_identity();

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_box_sel", box_sel, 0);
    chk("rst_rd_en", box_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_error", error, 0);
    chk("rst_opens", opens_used, 0);

    // Self-pointing box, start on the first edge with rst=1
    launch(8'd7);
    chk("s1_busy", busy, 1);
    chk("s1_rd_en", box_rd_en, 1);
    chk("s1_sel", box_sel, 7);
    wait_done(50, -1, lat);
    chk("s1_lat", lat, 2);
    chk("s1_found", found, 1);
    chk("s1_error", error, 0);
    chk("s1_opens", opens_used, 1);
    chk("s1_nsel", nsel, 1);
    after_done("s1");
    chk("s1_found_held", found, 1);

    // Chain 3 -> 9 -> 40 -> 3
    set_identity();
    mem[3] = 8'd9; mem[9] = 8'd40; mem[40] = 8'd3;
    launch(8'd3);
    wait_done(50, -1, lat);
    chk("s2_lat", lat, 6);
    chk("s2_found", found, 1);
    chk("s2_opens", opens_used, 3);
    chk("s2_nsel", nsel, 3);
    chk("s2_sel0", sel_log[0], 3);
    chk("s2_sel1", sel_log[1], 9);
    chk("s2_sel2", sel_log[2], 40);
    after_done("s2");

    // 50-box cycle: 12 -> 50 -> 51 -> ... -> 98 -> 12
    set_identity();
    mem[12] = 8'd50;
    for (int i = 50; i < 98; i++) mem[i] = 8'(i + 1);
    mem[98] = 8'd12;
    launch(8'd12);
    wait_done(300, -1, lat);
    chk("s3_lat", lat, 100);
    chk("s3_found", found, 1);
    chk("s3_opens", opens_used, 50);
    chk("s3_error", error, 0);
    after_done("s3");

    // 51-box cycle: budget runs out one box short
    mem[98] = 8'd99; mem[99] = 8'd12;
    launch(8'd12);
    wait_done(300, -1, lat);
    chk("s4_lat", lat, 100);
    chk("s4_found", found, 0);
    chk("s4_opens", opens_used, 50);
    chk("s4_error", error, 0);
    chk("s4_last_sel", sel_log[49], 98);
    after_done("s4");

    // Illegal box content
    set_identity();
    mem[20] = 8'd200;
    launch(8'd20);
    wait_done(50, -1, lat);
    chk("s5_lat", lat, 2);
    chk("s5_error", error, 1);
    chk("s5_found", found, 0);
    chk("s5_opens", opens_used, 1);
    after_done("s5");

    // Illegal prisoner id: no openings, done after the sampling edge
    launch(8'd150);
    wait_done(50, -1, lat);
    chk("s6_lat", lat, 0);
    chk("s6_error", error, 1);
    chk("s6_found", found, 0);
    chk("s6_opens", opens_used, 0);
    chk("s6_nsel", nsel, 0);
    after_done("s6");

    // Start while busy is ignored and not queued
    mem[3] = 8'd9; mem[9] = 8'd40; mem[40] = 8'd3;
    launch(8'd3);
    wait_done(200, 2, lat);
    chk("s8_lat", lat, 6);
    chk("s8_found", found, 1);
    chk("s8_opens", opens_used, 3);
    chk("s8_error", error, 0);
    after_done("s8");
    @(negedge clk);
    chk("s8_not_queued", busy, 0);

    // Start during the done cycle is ignored; held one more cycle it is taken
    launch(8'd3);
    wait_done(50, -1, lat);
    chk("s9_lat", lat, 6);
    start = 1'b1; prisoner_id = 8'd7;
    @(negedge clk);
    chk("s9_done_cycle_ignored", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("s9_accepted", busy, 1);
    wait_done(50, -1, lat);
    chk("s9b_lat", lat, 2);
    chk("s9b_found", found, 1);
    chk("s9b_opens", opens_used, 1);
    after_done("s9b");

    // Reset in the third cycle of a long search
    set_identity();
    mem[12] = 8'd50;
    for (int i = 50; i < 99; i++) mem[i] = 8'(i + 1);
    mem[99] = 8'd12;
    launch(8'd12);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("s7_box_sel", box_sel, 0);
    chk("s7_rd_en", box_rd_en, 0);
    chk("s7_busy", busy, 0);
    chk("s7_done", done, 0);
    chk("s7_found", found, 0);
    chk("s7_error", error, 0);
    chk("s7_opens", opens_used, 0);
    rst = 1'b1;
    dcount = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("s7_no_done", dcount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
